mem_access_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one word-addressed simulation memory between NUM_REQ command ports, such as DPI-driven host tasks. Each port issues single read or write commands. The block grants one command at a time, models a fixed ACCESS_LATENCY, and returns a result word on the shared response bus with a per-port strobe. It owns the memory array and clears it to zero after every reset.

---
 rtl/mem_access_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter that serializes single-word read/write commands from
// NUM_REQ ports onto one owned memory, with fixed access latency and zero-fill after reset.
module mem_access_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned MEM_DEPTH      = 1024,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ACCESS_LATENCY = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*32-1:0]            req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             busy,
    output logic [31:0]                      cycle_count
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           clr_idx_q, clr_idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           rr_q, rr_d;
    logic [PW-1:0]           port_q, port_d;
    logic                    wr_q, wr_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [31:0]             cycle_q, cycle_d;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic                    mem_we;
    logic [AW-1:0]           mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    gnt_found;
    logic [PW-1:0]           gnt_idx;
    logic [PW-1:0]           cand;
    logic                    sel_write;
    logic [31:0]             sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    accept;
    logic                    in_range;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Round-robin search starting just after the last granted port.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = PW'((32'(rr_q) + off) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Command fields of the winning port.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[32*i +: 32];
                sel_wdata = req_wdata[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // RESP also arbitrates so back-to-back commands are accepted one cycle after a response.
    assign accept = gnt_found && !rst && ((state_q == S_IDLE) || (state_q == S_RESP));

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign in_range = (addr_q < 32'(MEM_DEPTH));
    assign rd_word  = mem_q[addr_q[AW-1:0]];

    // Next-state, datapath and memory write control.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        port_d      = port_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        cycle_d     = cycle_q + 32'd1;
        mem_we      = 1'b0;
        mem_waddr   = clr_idx_q;
        mem_wdata   = '0;

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(MEM_DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (accept) begin
                    wr_d    = sel_write;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    port_d  = gnt_idx;
                    rr_d    = gnt_idx;
                    cnt_d   = CW'(ACCESS_LATENCY - 1);
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d             = S_RESP;
                    rsp_valid_d[port_q] = 1'b1;
                    if (wr_q) begin
                        if (in_range) begin
                            mem_we     = 1'b1;
                            mem_waddr  = addr_q[AW-1:0];
                            mem_wdata  = wdata_q;
                            rsp_data_d = DATA_WIDTH'(1);
                        end else begin
                            rsp_data_d = '0;
                        end
                    end else begin
                        rsp_data_d = in_range ? rd_word : '1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            clr_idx_q   <= '0;
            cnt_q       <= '0;
            rr_q        <= PW'(NUM_REQ - 1);
            port_q      <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            cycle_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            port_q      <= port_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cycle_q     <= cycle_d;
        end
    end

    // An in-flight write is dropped if reset lands on its commit edge.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = (state_q != S_IDLE);
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: a reference memory model fills a
// scoreboard at each grant; captured responses are matched against it.
module tb_mem_access_arbiter;

    localparam int NR    = 4;
    localparam int PW    = 2;
    localparam int DEPTH = 1024;
    localparam int DW    = 32;
    localparam int LAT   = 10;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          acc;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     cmd_valid;
    logic [NR-1:0]     cmd_w;
    logic [31:0]       cmd_a [NR];
    logic [31:0]       cmd_d [NR];
    logic [NR*32-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              busy;
    logic [31:0]       cycle_count;

    logic [31:0]       mdl [DEPTH];
    sb_t               sb [$];
    int                last;
    int                rd_n;
    int                pass_n;
    int                fail_n;
    int                total_n;

    int                edge_n;
    int                wr_n;
    int                multi_rdy;
    logic [NR-1:0]     cap_port [256];
    logic [31:0]       cap_data [256];
    int                cap_edge [256];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_addr[32*i +: 32]  = cmd_a[PW'(i)];
            req_wdata[DW*i +: DW] = cmd_d[PW'(i)];
        end
    end

    mem_access_arbiter #(
        .NUM_REQ(NR),
        .MEM_DEPTH(DEPTH),
        .DATA_WIDTH(DW),
        .ACCESS_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(cmd_valid),
        .req_ready(req_ready),
        .req_write(cmd_w),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy),
        .cycle_count(cycle_count)
    );

    always @(posedge clk) edge_n <= edge_n + 1;

    // Capture every response strobe and flag any multi-hot ready.
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            cap_port[8'(wr_n)] <= rsp_valid;
            cap_data[8'(wr_n)] <= rsp_data;
            cap_edge[8'(wr_n)] <= edge_n;
            wr_n               <= wr_n + 1;
        end
        if (!$onehot0(req_ready)) multi_rdy <= multi_rdy + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_w[PW'(p)] = w;
        cmd_a[PW'(p)] = a;
        cmd_d[PW'(p)] = d;
    endtask

    function automatic int next_rr();
        for (int off = 1; off <= NR; off++) begin
            if (cmd_valid[PW'((last + off) % NR)]) return (last + off) % NR;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_exec(input int p);
        logic [PW-1:0] q;
        q = PW'(p);
        if (cmd_w[q]) begin
            if (cmd_a[q] < 32'(DEPTH)) begin
                mdl[cmd_a[q][9:0]] = cmd_d[q];
                return 32'd1;
            end
            return 32'd0;
        end
        if (cmd_a[q] < 32'(DEPTH)) return mdl[cmd_a[q][9:0]];
        return 32'hFFFF_FFFF;
    endfunction

    // Raise valid on mask and accept n grants; keep=1 holds valid after a grant.
    task automatic serve(input logic [NR-1:0] mask, input int n, input bit keep);
        int  got;
        int  budget;
        int  prev;
        int  g;
        int  ep;
        sb_t e;
        got    = 0;
        budget = 0;
        prev   = -1;
        cmd_valid = cmd_valid | mask;
        while (got < n) begin
            #1;
            if (req_ready != '0) begin
                g = 0;
                for (int i = NR - 1; i >= 0; i--) if (req_ready[PW'(i)]) g = i;
                ep = next_rr();
                check("grant_port", 32'(g), 32'(ep));
                if (prev >= 0) check("accept_spacing", 32'(edge_n + 1 - prev), 32'(LAT + 1));
                prev   = edge_n + 1;
                e.port = g;
                e.data = model_exec(g);
                e.acc  = edge_n + 1;
                sb.push_back(e);
                last = g;
                got++;
                @(posedge clk);
                #1;
                if (!keep || got == n) cmd_valid[PW'(g)] = 1'b0;
                @(negedge clk);
            end else begin
                budget++;
                if (budget > 3000) begin
                    check("grant_timeout", 32'(got), 32'(n));
                    break;
                end
                @(negedge clk);
            end
        end
        cmd_valid = cmd_valid & ~mask;
    endtask

    // Match captured responses against the scoreboard.
    task automatic drain();
        int          b;
        logic [7:0]  idx;
        sb_t         e;
        b = 0;
        while ((wr_n - rd_n) < sb.size() && b < 300) begin
            @(negedge clk);
            b++;
        end
        repeat (2) @(negedge clk);
        #1;
        while (rd_n < wr_n) begin
            idx = 8'(rd_n);
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(cap_port[idx]), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_port", 32'(cap_port[idx]), 32'(1 << e.port));
                check("rsp_data", cap_data[idx], e.data);
                check("rsp_latency", 32'(cap_edge[idx] - e.acc), 32'(LAT));
            end
            rd_n++;
        end
        if (sb.size() != 0) begin
            check("missing_rsp", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < DEPTH; i++) mdl[10'(i)] = '0;
        last = NR - 1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cycle_count", cycle_count, 32'd0);
    endtask

    initial begin
        int          zeros;
        logic [31:0] c0;
        rst       = 1'b1;
        cmd_valid = '0;
        cmd_w     = '0;
        rd_n      = 0;
        pass_n    = 0;
        fail_n    = 0;
        total_n   = 0;
        last      = NR - 1;

        // Reset with every port requesting: no grant during the clear sweep.
        for (int p = 0; p < NR; p++) set_cmd(p, 1'b0, 32'd5, 32'd0);
        cmd_valid = '1;
        do_reset();
        zeros = 1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (req_ready != '0) break;
            zeros++;
        end
        check("clear_ready_low_cycles", 32'(zeros), 32'd1024);
        check("first_grant_after_clear", 32'(req_ready), 32'b0001);
        cmd_valid = 4'b0001;
        serve(4'b0001, 1, 1'b0);
        drain();

        // Write then read back on port 0.
        set_cmd(0, 1'b1, 32'd3, 32'hDEAD_BEEF);
        serve(4'b0001, 1, 1'b0);
        drain();
        set_cmd(0, 1'b0, 32'd3, 32'd0);
        serve(4'b0001, 1, 1'b0);
        drain();

        // Address range edges.
        set_cmd(0, 1'b0, 32'd1024, 32'd0);
        serve(4'b0001, 1, 1'b0);
        drain();
        set_cmd(0, 1'b1, 32'd2000, 32'h55);
        serve(4'b0001, 1, 1'b0);
        drain();
        set_cmd(3, 1'b0, 32'd1023, 32'd0);
        serve(4'b1000, 1, 1'b0);
        drain();

        // All ports continuously valid: rotation 0,1,2,3,0.
        for (int p = 0; p < NR; p++) set_cmd(p, 1'b0, 32'd3, 32'd0);
        serve(4'b1111, 5, 1'b1);
        drain();

        // Port 1 write and port 2 read of the same word raised together.
        set_cmd(1, 1'b1, 32'd7, 32'h0000_1234);
        set_cmd(2, 1'b0, 32'd7, 32'd0);
        serve(4'b0110, 2, 1'b0);
        drain();
        check("rsp_data_hold", rsp_data, 32'h0000_1234);
        check("idle_busy", 32'(busy), 32'd0);
        c0 = cycle_count;
        repeat (3) @(negedge clk);
        #1;
        check("cycle_count_step", cycle_count - c0, 32'd3);

        // Reset five cycles into a write: no response, no commit.
        set_cmd(3, 1'b1, 32'd9, 32'h0000_ABCD);
        serve(4'b1000, 1, 1'b0);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (15) @(negedge clk);
        #1;
        check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
        set_cmd(0, 1'b0, 32'd9, 32'd0);
        serve(4'b0001, 1, 1'b0);
        drain();

        check("ready_onehot_violations", 32'(multi_rdy), 32'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
